// File: rtl/mips_mem_loader.sv
// mips_mem_loader: boot-time loader that turns a framed byte stream
// (LEN_HI, LEN_LO, then 4*N big-endian data bytes) into sequential 32-bit
// RAM writes while holding the CPU in reset.
// Optional build macro: MEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte after the last data word; a mismatch ends the load in the error state.
module mips_mem_loader #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              res,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

`ifdef MEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_ERR, S_CHK
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_t;
`endif

  // Largest legal word count is the full RAM depth (every word written once).
  localparam logic [16:0]       DEPTH = 17'(1) << ADDR_W;
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);

  state_t              state_q, state_d;
  logic [15:0]         len_q;
  logic [1:0]          byte_cnt_q;
  logic [DATA_W-9:0]   wbuf_q;
  logic                xfer;
  logic                restart;
  logic [15:0]         n_word;
  logic [ADDR_W:0]     wl_next;
  logic                last_word;
`ifdef MEM_LOADER_CHECKSUM_EN
  logic [7:0]          chk_q;
`endif

  assign xfer      = s_valid && s_ready;
  assign restart   = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
  assign n_word    = {len_q[15:8], s_data};
  // words_loaded doubles as the running word index of the current load.
  assign wl_next   = words_loaded + 1'b1;
  assign last_word = (17'(wl_next) == {1'b0, len_q});

  assign mem_we   = (state_q == S_WRITE);
  assign done     = (state_q == S_DONE);
  assign err      = (state_q == S_ERR);
  assign cpu_hold = (state_q != S_DONE);

  // Next-state decode; s_ready depends only on state, never on s_valid.
  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    busy    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (xfer) state_d = S_LEN_LO;
      end
      S_LEN_LO: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (xfer) begin
          if (n_word == 16'd0)                state_d = S_DONE;
          else if ({1'b0, n_word} > DEPTH)    state_d = S_ERR;
          else                                state_d = S_DATA;
        end
      end
      S_DATA: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (xfer && byte_cnt_q == 2'd3) state_d = S_WRITE;
      end
      S_WRITE: begin
        busy = 1'b1;
`ifdef MEM_LOADER_CHECKSUM_EN
        if (last_word) state_d = S_CHK;
`else
        if (last_word) state_d = S_DONE;
`endif
        else           state_d = S_DATA;
      end
`ifdef MEM_LOADER_CHECKSUM_EN
      S_CHK: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (xfer) state_d = (s_data == chk_q) ? S_DONE : S_ERR;
      end
`endif
      S_DONE, S_ERR: begin
        if (start) state_d = S_LEN_HI;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, length capture, word assembly and RAM write-port registers.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      byte_cnt_q   <= '0;
      wbuf_q       <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      words_loaded <= '0;
`ifdef MEM_LOADER_CHECKSUM_EN
      chk_q        <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (restart) begin
        words_loaded <= '0;
        byte_cnt_q   <= '0;
`ifdef MEM_LOADER_CHECKSUM_EN
        chk_q        <= '0;
`endif
      end
      if (xfer) begin
        case (state_q)
          S_LEN_HI: len_q[15:8] <= s_data;
          S_LEN_LO: len_q[7:0]  <= s_data;
          S_DATA: begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            wbuf_q     <= {wbuf_q[DATA_W-17:0], s_data};
`ifdef MEM_LOADER_CHECKSUM_EN
            chk_q      <= chk_q ^ s_data;
`endif
            // 4th byte: present the finished word for the WRITE cycle.
            if (byte_cnt_q == 2'd3) begin
              mem_wdata <= {wbuf_q, s_data};
              mem_addr  <= BASE + words_loaded[ADDR_W-1:0];
            end
          end
          default: ;
        endcase
      end
      if (state_q == S_WRITE) words_loaded <= wl_next;
    end
  end

endmodule

// File: tb/tb_mips_mem_loader.sv
// Directed bench for mips_mem_loader: two instances share one stream, one at
// BASE_ADDR=0 and one at BASE_ADDR=255 to observe address wrap.
module tb_mips_mem_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       res, start, s_valid;
  logic [7:0] s_data;

  logic        s_ready_a, mem_we_a, cpu_hold_a, busy_a, done_a, err_a;
  logic [7:0]  mem_addr_a;
  logic [31:0] mem_wdata_a;
  logic [8:0]  words_loaded_a;

  logic        s_ready_b, mem_we_b, cpu_hold_b, busy_b, done_b, err_b;
  logic [7:0]  mem_addr_b;
  logic [31:0] mem_wdata_b;
  logic [8:0]  words_loaded_b;

  mips_mem_loader #(.ADDR_W(8), .DATA_W(32), .BASE_ADDR(0)) dut (
    .clk(clk), .res(res), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .cpu_hold(cpu_hold_a), .busy(busy_a),
    .done(done_a), .err(err_a), .words_loaded(words_loaded_a)
  );

  mips_mem_loader #(.ADDR_W(8), .DATA_W(32), .BASE_ADDR(255)) dut_b (
    .clk(clk), .res(res), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .cpu_hold(cpu_hold_b), .busy(busy_b),
    .done(done_b), .err(err_b), .words_loaded(words_loaded_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Record every RAM write of both instances.
  logic [39:0] wq[$];
  logic [39:0] bq[$];
  always @(negedge clk) begin
    if (mem_we_a === 1'b1) begin
      wq.push_back({mem_addr_a, mem_wdata_a});
      check("ready_low_in_write", {63'd0, s_ready_a}, 64'd0);
    end
    if (mem_we_b === 1'b1) bq.push_back({mem_addr_b, mem_wdata_b});
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    repeat (gap) begin
      @(negedge clk);
      s_valid = 1'b0;
    end
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = b;
    while (s_ready_a !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("ready_seen", {63'd0, s_ready_a}, 64'd1);
    @(posedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    s_valid = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  // Leaves the bench at the first negedge after the frame has fully ended.
  task automatic end_frame(input logic [7:0] c);
`ifdef MEM_LOADER_CHECKSUM_EN
    send_byte(c, 0);
    @(negedge clk);
    s_valid = 1'b0;
`else
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    if (c == 8'hFF) s_valid = 1'b0;
`endif
  endtask

  task automatic verify_two_words();
    check("nwrites", 64'(wq.size()), 64'd2);
    check("nwrites_b", 64'(bq.size()), 64'd2);
    if (wq.size() >= 2) begin
      check("write0", 64'(wq[0]), {24'd0, 8'h00, 32'h12345678});
      check("write1", 64'(wq[1]), {24'd0, 8'h01, 32'hAABBCCDD});
    end
    if (bq.size() >= 2) begin
      check("wrap_write0", 64'(bq[0]), {24'd0, 8'hFF, 32'h12345678});
      check("wrap_write1", 64'(bq[1]), {24'd0, 8'h00, 32'hAABBCCDD});
    end
  endtask

  logic [7:0] frame [0:9];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    res = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;

    // 1. reset state
    repeat (2) @(negedge clk);
    check("rst_cpu_hold", {63'd0, cpu_hold_a}, 64'd1);
    check("rst_s_ready", {63'd0, s_ready_a}, 64'd0);
    check("rst_mem_we", {63'd0, mem_we_a}, 64'd0);
    check("rst_done", {63'd0, done_a}, 64'd0);
    check("rst_err", {63'd0, err_a}, 64'd0);
    check("rst_busy", {63'd0, busy_a}, 64'd0);
    check("rst_words", 64'(words_loaded_a), 64'd0);
    check("rst_addr", 64'(mem_addr_a), 64'd0);
    check("rst_wdata", 64'(mem_wdata_a), 64'd0);
    res = 1'b0;

    // 2. two-word load, back to back (XOR of data bytes is 0x08)
    wq.delete(); bq.delete();
    pulse_start();
    check("t2_busy", {63'd0, busy_a}, 64'd1);
    for (int i = 0; i < 10; i++) send_byte(frame[i], 0);
    end_frame(8'h08);
    check("t2_done", {63'd0, done_a}, 64'd1);
    check("t2_err", {63'd0, err_a}, 64'd0);
    check("t2_cpu_hold", {63'd0, cpu_hold_a}, 64'd0);
    check("t2_busy_end", {63'd0, busy_a}, 64'd0);
    check("t2_words", 64'(words_loaded_a), 64'd2);
    verify_two_words();

    // 3. zero-length frame
    wq.delete(); bq.delete();
    pulse_start();
    check("t3_done_cleared", {63'd0, done_a}, 64'd0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    s_valid = 1'b0;
    check("t3_done", {63'd0, done_a}, 64'd1);
    check("t3_cpu_hold", {63'd0, cpu_hold_a}, 64'd0);
    check("t3_words", 64'(words_loaded_a), 64'd0);
    check("t3_nwrites", 64'(wq.size()), 64'd0);

    // 4. oversize count 257 > 256
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    @(negedge clk);
    s_valid = 1'b0;
    check("t4_err", {63'd0, err_a}, 64'd1);
    check("t4_cpu_hold", {63'd0, cpu_hold_a}, 64'd1);
    check("t4_done", {63'd0, done_a}, 64'd0);
    check("t4_nwrites", 64'(wq.size()), 64'd0);
    pulse_start();
    check("t4_err_cleared", {63'd0, err_a}, 64'd0);
    check("t4_busy", {63'd0, busy_a}, 64'd1);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    s_valid = 1'b0;
    check("t4_recover_done", {63'd0, done_a}, 64'd1);

    // 5. same load with random stalls, stray start in DATA ignored
    wq.delete(); bq.delete();
    pulse_start();
    send_byte(frame[0], int'($urandom_range(0, 3)));
    send_byte(frame[1], int'($urandom_range(0, 3)));
    pulse_start();
    check("t5_start_ignored", {63'd0, busy_a}, 64'd1);
    for (int i = 2; i < 10; i++) send_byte(frame[i], int'($urandom_range(0, 4)));
    end_frame(8'h08);
    check("t5_done", {63'd0, done_a}, 64'd1);
    check("t5_words", 64'(words_loaded_a), 64'd2);
    check("t5_done_b", {63'd0, done_b}, 64'd1);
    verify_two_words();

`ifdef MEM_LOADER_CHECKSUM_EN
    // checksum mismatch: words stay written, load ends in error
    wq.delete(); bq.delete();
    pulse_start();
    for (int i = 0; i < 10; i++) send_byte(frame[i], 0);
    end_frame(8'h09);
    check("chk_err", {63'd0, err_a}, 64'd1);
    check("chk_cpu_hold", {63'd0, cpu_hold_a}, 64'd1);
    verify_two_words();
`endif

    // 6. reset after two data bytes aborts the load
    wq.delete(); bq.delete();
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(frame[i], 0);
    @(negedge clk);
    s_valid = 1'b0;
    res     = 1'b1;
    @(negedge clk);
    res     = 1'b0;
    check("t6_cpu_hold", {63'd0, cpu_hold_a}, 64'd1);
    check("t6_busy", {63'd0, busy_a}, 64'd0);
    check("t6_s_ready", {63'd0, s_ready_a}, 64'd0);
    check("t6_done", {63'd0, done_a}, 64'd0);
    check("t6_err", {63'd0, err_a}, 64'd0);
    check("t6_words", 64'(words_loaded_a), 64'd0);
    check("t6_addr", 64'(mem_addr_a), 64'd0);
    check("t6_wdata", 64'(mem_wdata_a), 64'd0);
    s_valid = 1'b1;
    s_data  = 8'h56;
    repeat (10) @(negedge clk);
    s_valid = 1'b0;
    check("t6_nwrites", 64'(wq.size()), 64'd0);
    check("t6_still_idle", {63'd0, busy_a}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
